// File: rtl/debounce_bank_pkg.sv
// Shared constants for the debounce bank: default parameter values and the
// legal range of each parameter, plus a small range-test helper.
package debounce_bank_pkg;

    localparam int CHANNELS_DEF    = 4;
    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 32;

    localparam int COUNT_W_DEF     = 3;
    localparam int COUNT_W_MIN     = 1;
    localparam int COUNT_W_MAX     = 24;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    localparam logic RESET_STATE_DEF = 1'b0;

    // True when value lies inside [lo, hi]; used for elaboration-time checks.
    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter, debounced
// level and registered rise/fall pulses. 'toggle' is the combinational
// "state flips on this edge" indicator so the top can register any_change
// in the same cycle as the pulses.
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int   COUNT_W     = COUNT_W_DEF,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RESET_STATE = RESET_STATE_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall,
    output logic toggle
);

    typedef logic [COUNT_W-1:0] count_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   mismatch;
    count_t                 count;

    assign sync_out = sync[SYNC_STAGES-1];
    assign mismatch = (sync_out != state);
    assign toggle   = mismatch && (count == '1);

    // Synchroniser: shift the asynchronous level through SYNC_STAGES flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync <= {SYNC_STAGES{RESET_STATE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Stability counter and debounced level; any agreement clears the count,
    // and the count wraps to zero on the edge where state flips.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count <= '0;
            state <= RESET_STATE;
        end else if (!mismatch) begin
            count <= '0;
        end else if (toggle) begin
            count <= '0;
            state <= ~state;
        end else begin
            count <= count + count_t'(1);
        end
    end

    // Edge pulses: high for the single cycle after state changes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= toggle && !state;
            fall <= toggle &&  state;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs. Each bit gets its own
// debounce_channel; any_change is the registered OR of all channel toggles,
// so it lines up with the rise/fall pulses.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int   CHANNELS    = CHANNELS_DEF,
    parameter int   COUNT_W     = COUNT_W_DEF,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RESET_STATE = RESET_STATE_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] raw_input,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    // Reject out-of-range parameters at elaboration.
    if (!in_range(CHANNELS, CHANNELS_MIN, CHANNELS_MAX)) begin : g_bad_channels
        $error("debounce_bank: CHANNELS out of range");
    end
    if (!in_range(COUNT_W, COUNT_W_MIN, COUNT_W_MAX)) begin : g_bad_count_w
        $error("debounce_bank: COUNT_W out of range");
    end
    if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES out of range");
    end

    logic [CHANNELS-1:0] toggle;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .COUNT_W     (COUNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_STATE (RESET_STATE)
        ) u_channel (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .raw    (raw_input[i]),
            .state  (state[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .toggle (toggle[i])
        );
    end

    // Registered change flag, asserted in the same cycle as any pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |toggle;
        end
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter COUNT_W, default 3: debounce counter width; an input must be stable for 2^COUNT_W cycles; legal range 1..24.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per channel; legal range 2..4.
REQ-004 Parameter RESET_STATE, default 0: 1-bit level loaded into synchronisers and debounced state at reset.
REQ-005 CLK  input  1  single clock; all logic on rising edge.
REQ-006 RST_N  input  1  reset, synchronous, active-low.
REQ-007 raw_input  input  CHANNELS  asynchronous switch/button levels, one bit per channel.
REQ-008 state  output  CHANNELS  debounced level per channel, registered.
REQ-009 rise  output  CHANNELS  one-cycle pulse when state goes 0->1, registered.
REQ-010 fall  output  CHANNELS  one-cycle pulse when state goes 1->0, registered.
REQ-011 any_change  output  1  registered OR of (rise | fall) across all channels, same cycle as the pulses.

Function
REQ-012 Each channel shall pass raw_input through a SYNC_STAGES-deep flop chain; only the last stage (sync_out) feeds the debounce logic.
REQ-013 Channels shall be fully independent; no channel's input affects another's state, counter or pulses.
REQ-014 Per channel: while sync_out == state, the counter shall load 0 on every edge.
REQ-015 While sync_out != state, the counter shall increment by 1 per edge; on the edge where it is all-ones, state shall invert and the counter shall wrap to 0.
REQ-016 Latency: a clean level change that persists shall appear on state at the (SYNC_STAGES + 2^COUNT_W)-th rising edge, counting the edge that first samples the new level as edge 1.
REQ-017 Any return of sync_out to equal state before the toggle edge shall clear the counter; the next mismatch restarts from 0 (no accumulation across glitches).
REQ-018 rise[i] shall be 1 for exactly the cycle following the edge on which state[i] becomes 1; fall[i] likewise for becoming 0; otherwise 0.
REQ-019 rise[i] and fall[i] shall never be 1 simultaneously; multiple channels may pulse in the same cycle.
REQ-020 any_change shall assert in exactly the cycles where any rise or fall bit is 1.
REQ-021 A mismatch persisting beyond the toggle makes state equal sync_out, so no further toggles occur; an input alternating every 2^COUNT_W+ cycles shall produce one toggle per stable interval.
REQ-022 Counter arithmetic shall be unsigned COUNT_W bits with natural wrap; no saturation logic.

Reset
REQ-023 On any rising edge with RST_N low: all synchroniser flops and state = RESET_STATE, counters = 0, rise = fall = 0, any_change = 0.
REQ-024 Reset asserted mid-count shall discard the count; no pulse shall be generated by reset itself, even if state changes value.
REQ-025 After RST_N rises, the first edge shall resample raw_input; latency per REQ-016 applies from that edge.

Structure
REQ-026 A shared package shall hold the parameter legal-range constants and the default values; no typedefs needed beyond a COUNT_W-wide counter type.
REQ-027 One sub-module, debounce_channel (synchroniser + counter + state + edge pulses for one bit), shall be instantiated CHANNELS times via generate; any_change is built in the top.
REQ-028 Illegal parameters shall be rejected at elaboration.

Verification (defaults: CHANNELS=4, COUNT_W=3, SYNC_STAGES=2, RESET_STATE=0; latency 10)
REQ-029 Reset: hold RST_N low 3 cycles with raw_input=4'hF -> state=0, rise=fall=0, any_change=0 throughout; no pulse at release.
REQ-030 Clean edge: raw_input[0] 0->1 after reset, held -> state[0]=1 at edge 10, rise[0]=1 and any_change=1 for exactly one cycle, fall=0.
REQ-031 Glitch: raw_input[1] high for 7 cycles then low -> state[1] stays 0, no pulses; then high for 9 cycles -> state[1] toggles once, then falls again 10 edges after the input drops.
REQ-032 Concurrency: raw_input 4'h0->4'hF same edge -> state=4'hF on the same edge, rise=4'hF for one cycle, any_change single pulse.
REQ-033 Reset mid-count: raw_input[2]=1 for 6 cycles, assert RST_N low 1 cycle, release -> state[2]=0 until 10 edges after release, no pulses in between.
REQ-034 Parameter sweep: COUNT_W=1, SYNC_STAGES=4, RESET_STATE=1 -> state=4'hF after reset, a held 1->0 change shows on state at edge 6 with one fall pulse.
